// File: rtl/rc4_pkg.sv
// Shared types, constants and the PRGA keystream selection helper for the RC4 core.
package rc4_pkg;

  localparam int unsigned SBOX_SIZE = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT,
    KSA,
    DROP,
    STREAM
  } state_e;

  // Keystream byte S[a+b] as seen after the swap of S[i'] and S[j'], built
  // from pre-swap reads: a and b have traded places, all other entries are unchanged.
  function automatic logic [7:0] prga_ks(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [7:0] ip,
                                         input logic [7:0] jp,
                                         input logic [7:0] s_t);
    logic [7:0] t;
    t = a + b;
    if (t == jp) begin
      prga_ks = a;
    end else if (t == ip) begin
      prga_ks = b;
    end else begin
      prga_ks = s_t;
    end
  endfunction

endpackage

// File: rtl/rc4_sbox.sv
// 256x8 RC4 state array: identity bulk load, one swap per cycle, three async reads.
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic       CLK,
  input  logic       init_en,
  input  logic       swap_en,
  input  logic [7:0] addr_a,
  input  logic [7:0] addr_b,
  input  logic [7:0] addr_t,
  output logic [7:0] data_a,
  output logic [7:0] data_b,
  output logic [7:0] data_t
);

  logic [7:0] s [SBOX_SIZE];

  // Identity load wins over a swap; contents are undefined until the first load.
  always_ff @(posedge CLK) begin
    if (init_en) begin
      for (int unsigned k = 0; k < SBOX_SIZE; k++) begin
        s[k] <= 8'(k);
      end
    end else if (swap_en) begin
      s[addr_a] <= data_b;
      s[addr_b] <= data_a;
    end
  end

  // Reads return the pre-swap contents; the caller resolves the swap collision.
  assign data_a = s[addr_a];
  assign data_b = s[addr_b];
  assign data_t = s[addr_t];

endmodule

// File: rtl/rc4_stream.sv
// RC4 stream cipher: variable-length key load, KSA, optional drop, then XOR streaming.
module rc4_stream
  import rc4_pkg::*;
#(
  parameter int unsigned MAX_KEY_BYTES = 32,
  parameter int unsigned DROP_N        = 0,
  parameter int unsigned LW            = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic          CLK_IN,
  input  logic          RESET_N_IN,
  input  logic          START_IN,
  input  logic          STOP_IN,
  input  logic          HOLD_IN,
  input  logic [LW-1:0] KEY_LEN_IN,
  input  logic [7:0]    KEY_BYTE_IN,
  input  logic          KEY_VALID_IN,
  output logic          KEY_READY_OUT,
  input  logic [7:0]    PLAIN_BYTE_IN,
  input  logic          PLAIN_VALID_IN,
  output logic          PLAIN_READY_OUT,
  output logic [7:0]    ENC_BYTE_OUT,
  output logic          ENC_VALID_OUT,
  input  logic          ENC_READY_IN,
  output logic          BUSY_OUT,
  output logic          ERROR_OUT
);

  localparam int unsigned   AW        = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;
  localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_KEY_BYTES);
  localparam logic [15:0]   DROP_LAST = 16'(DROP_N - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] key_len_q, load_cnt_q, kidx_q;
  logic [7:0]    k_q, i_q, j_q;
  logic [15:0]   drop_cnt_q;
  logic [7:0]    key_buf [MAX_KEY_BYTES];
  logic          enc_valid_q, error_q;
  logic [7:0]    enc_byte_q;

  logic          start_ok, key_hs, plain_hs, load_last;
  logic          prga_step, sbox_init, sbox_swap;
  logic [7:0]    i_next, addr_a, rd_a, rd_b, rd_t, j_new, t_idx, ks, key_byte;

  assign start_ok  = (KEY_LEN_IN != '0) && (KEY_LEN_IN <= MAX_LEN);
  assign key_hs    = KEY_READY_OUT && KEY_VALID_IN;
  assign plain_hs  = PLAIN_READY_OUT && PLAIN_VALID_IN;
  assign load_last = (load_cnt_q == key_len_q - LW'(1));

  // One datapath serves both KSA (index k, key byte added) and PRGA (index i+1).
  assign i_next   = i_q + 8'd1;
  assign key_byte = key_buf[kidx_q[AW-1:0]];
  assign addr_a   = (state_q == KSA) ? k_q : i_next;
  assign j_new    = (state_q == KSA) ? (j_q + rd_a + key_byte) : (j_q + rd_a);
  assign t_idx    = rd_a + rd_b;
  assign ks       = prga_ks(rd_a, rd_b, i_next, j_new, rd_t);

  assign prga_step = !HOLD_IN && !STOP_IN && ((state_q == DROP) || plain_hs);
  assign sbox_init = !HOLD_IN && !STOP_IN && (state_q == INIT);
  assign sbox_swap = prga_step || (!HOLD_IN && !STOP_IN && (state_q == KSA));

  rc4_sbox u_sbox (
    .CLK     (CLK_IN),
    .init_en (sbox_init),
    .swap_en (sbox_swap),
    .addr_a  (addr_a),
    .addr_b  (j_new),
    .addr_t  (t_idx),
    .data_a  (rd_a),
    .data_b  (rd_b),
    .data_t  (rd_t)
  );

  // State register.
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; STOP_IN overrides everything, HOLD_IN freezes.
  always_comb begin
    state_d = state_q;
    if (STOP_IN) begin
      state_d = IDLE;
    end else if (!HOLD_IN) begin
      case (state_q)
        IDLE:    if (START_IN && start_ok) state_d = LOAD;
        LOAD:    if (key_hs && load_last) state_d = INIT;
        INIT:    state_d = KSA;
        KSA:     if (k_q == 8'hFF) state_d = (DROP_N == 0) ? STREAM : DROP;
        DROP:    if (drop_cnt_q == DROP_LAST) state_d = STREAM;
        STREAM:  state_d = STREAM;
        default: state_d = IDLE;
      endcase
    end
  end

  // Index and length counters; j is cleared after the KSA so the PRGA starts at i=j=0.
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      key_len_q  <= '0;
      load_cnt_q <= '0;
      kidx_q     <= '0;
      k_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      drop_cnt_q <= '0;
    end else if (STOP_IN) begin
      load_cnt_q <= '0;
      kidx_q     <= '0;
      k_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      drop_cnt_q <= '0;
    end else if (!HOLD_IN) begin
      case (state_q)
        IDLE: begin
          if (START_IN) begin
            key_len_q  <= KEY_LEN_IN;
            load_cnt_q <= '0;
          end
        end
        LOAD: begin
          if (key_hs) load_cnt_q <= load_cnt_q + LW'(1);
        end
        INIT: begin
          i_q        <= '0;
          j_q        <= '0;
          k_q        <= '0;
          kidx_q     <= '0;
          drop_cnt_q <= '0;
        end
        KSA: begin
          k_q    <= k_q + 8'd1;
          kidx_q <= (kidx_q == key_len_q - LW'(1)) ? '0 : kidx_q + LW'(1);
          j_q    <= (k_q == 8'hFF) ? 8'h00 : j_new;
        end
        DROP: begin
          i_q        <= i_next;
          j_q        <= j_new;
          drop_cnt_q <= drop_cnt_q + 16'd1;
        end
        STREAM: begin
          if (plain_hs) begin
            i_q <= i_next;
            j_q <= j_new;
          end
        end
        default: ;
      endcase
    end
  end

  // Key byte capture.
  always_ff @(posedge CLK_IN) begin
    if (key_hs) key_buf[load_cnt_q[AW-1:0]] <= KEY_BYTE_IN;
  end

  // Ciphertext output register and error pulse.
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      enc_valid_q <= 1'b0;
      enc_byte_q  <= '0;
      error_q     <= 1'b0;
    end else if (STOP_IN) begin
      enc_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      error_q <= !HOLD_IN && (state_q == IDLE) && START_IN && !start_ok;
      if (!HOLD_IN) begin
        if (plain_hs) begin
          enc_byte_q  <= PLAIN_BYTE_IN ^ ks;
          enc_valid_q <= 1'b1;
        end else if (ENC_READY_IN) begin
          enc_valid_q <= 1'b0;
        end
      end
    end
  end

  assign KEY_READY_OUT   = (state_q == LOAD) && !HOLD_IN;
  assign PLAIN_READY_OUT = (state_q == STREAM) && !HOLD_IN && (!enc_valid_q || ENC_READY_IN);
  assign ENC_VALID_OUT   = enc_valid_q;
  assign ENC_BYTE_OUT    = enc_byte_q;
  assign BUSY_OUT        = state_q inside {LOAD, INIT, KSA, DROP};
  assign ERROR_OUT       = error_q;

endmodule
